// File: rtl/map_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : map_write_arbiter_if
// Purpose  : Requester and map-memory write bus shared by map_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface map_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
);
  logic [NUM_REQ-1:0]                  wr_req;
  logic [0:NUM_REQ-1][ADDR_WIDTH-1:0]  wr_addr_req;
  logic [0:NUM_REQ-1][DATA_WIDTH-1:0]  wr_data_req;
  logic [NUM_REQ-1:0]                  wr_ready;
  logic [NUM_REQ-1:0]                  wr_done;
  logic                                we;
  logic [ADDR_WIDTH-1:0]               wr_addr;
  logic [DATA_WIDTH-1:0]               wr_data;

  // Requesters and the memory side together form the master view.
  modport master (
    output wr_req, wr_addr_req, wr_data_req,
    input  wr_ready, wr_done, we, wr_addr, wr_data
  );

  modport slave (
    input  wr_req, wr_addr_req, wr_data_req,
    output wr_ready, wr_done, we, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/map_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : map_write_arbiter
// Purpose  : One-entry write slots per requester, round-robin onto the
//            single registered tile-map write port.
// Revision : 1.0 - initial release
// ============================================================================
module map_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  map_write_arbiter_if.slave  bus,
  output logic                busy,
  output logic                overflow_err
);

  localparam int c_idx_w = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    r_pend;
  logic [ADDR_WIDTH-1:0] r_slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] r_slot_data [NUM_REQ];
  logic [c_idx_w-1:0]    r_rr_last;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [NUM_REQ-1:0]    r_wr_done;
  logic                  r_overflow;

  logic [NUM_REQ-1:0]    w_accept;
  logic [NUM_REQ-1:0]    w_drop;
  logic [NUM_REQ-1:0]    w_grant_oh;
  logic                  w_grant_vld;
  logic [c_idx_w-1:0]    w_grant_idx;

  assign w_accept = bus.wr_req & ~r_pend;
  assign w_drop   = bus.wr_req & r_pend;

  function automatic logic [c_idx_w-1:0] f_rr_index(input logic [c_idx_w-1:0] last,
                                                     input int offset);
    int s;
    s = int'(last) + offset;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return c_idx_w'(s);
  endfunction

  // Scan from farthest to nearest so the closest pending slot after rr_last wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (r_pend[f_rr_index(r_rr_last, off)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = f_rr_index(r_rr_last, off);
      end
    end
    if (w_grant_vld) w_grant_oh[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_rr_last  <= c_idx_w'(NUM_REQ - 1);
      r_we       <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_done  <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_slot_addr[i] <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      // Accepted and granted slots are always disjoint: accept needs ~pend.
      r_pend <= (r_pend & ~w_grant_oh) | w_accept;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_slot_addr[i] <= bus.wr_addr_req[i];
          r_slot_data[i] <= bus.wr_data_req[i];
        end
      end
      if (|w_drop) r_overflow <= 1'b1;
      r_we      <= w_grant_vld;
      r_wr_done <= w_grant_oh;
      if (w_grant_vld) begin
        r_wr_addr <= r_slot_addr[w_grant_idx];
        r_wr_data <= r_slot_data[w_grant_idx];
        r_rr_last <= w_grant_idx;
      end
    end
  end

  assign bus.wr_ready = ~r_pend;
  assign bus.wr_done  = r_wr_done;
  assign bus.we       = r_we;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign busy         = |r_pend;
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_map_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_write_arbiter
// Purpose  : Directed plus random stimulus on 2- and 3-requester arbiters,
//            checked against a slot/round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy2, ovf2, busy3, ovf3;

  always #5 clk = ~clk;

  map_write_arbiter_if #(.NUM_REQ(2)) bus2 ();
  map_write_arbiter_if #(.NUM_REQ(3)) bus3 ();

  map_write_arbiter #(.NUM_REQ(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .overflow_err(ovf2)
  );
  map_write_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy(busy3), .overflow_err(ovf3)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Stimulus for the next edge; index 0 drives the 2-requester unit, 1 the 3-requester unit.
  logic       s_rst;
  logic [2:0] s_req  [2];
  logic [7:0] s_addr [2][3];
  logic [1:0] s_data [2][3];

  // Reference model: slot contents, last granted index, and expected port state.
  logic [2:0] m_pend  [2];
  logic [7:0] m_saddr [2][3];
  logic [1:0] m_sdata [2][3];
  int         m_last  [2];
  logic       m_we    [2];
  logic [7:0] m_waddr [2];
  logic [1:0] m_wdata [2];
  logic [2:0] m_done  [2];
  logic       m_ovf   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int u);
    int n, g, k;
    logic [2:0] old;
    n = (u == 0) ? 2 : 3;
    if (s_rst) begin
      m_pend[u] = '0; m_last[u] = n - 1; m_we[u] = 1'b0;
      m_waddr[u] = '0; m_wdata[u] = '0; m_done[u] = '0; m_ovf[u] = 1'b0;
    end else begin
      old = m_pend[u];
      g = -1;
      for (int off = 1; off <= n; off++) begin
        k = (m_last[u] + off) % n;
        if (g < 0 && old[k]) g = k;
      end
      if (g >= 0) begin
        m_we[u] = 1'b1; m_waddr[u] = m_saddr[u][g]; m_wdata[u] = m_sdata[u][g];
        m_done[u] = 3'(1 << g); m_pend[u][g] = 1'b0; m_last[u] = g;
      end else begin
        m_we[u] = 1'b0; m_done[u] = '0;
      end
      for (int i = 0; i < n; i++) begin
        if (s_req[u][i]) begin
          if (old[i]) m_ovf[u] = 1'b1;
          else begin
            m_pend[u][i] = 1'b1; m_saddr[u][i] = s_addr[u][i]; m_sdata[u][i] = s_data[u][i];
          end
        end
      end
    end
  endtask

  task automatic check_unit(input int u);
    logic [31:0] a_we, a_addr, a_data, a_done, a_ready, a_busy, a_ovf;
    logic [2:0]  mask;
    int n;
    if (u == 0) begin
      n = 2; mask = 3'b011;
      a_we = 32'(bus2.we); a_addr = 32'(bus2.wr_addr); a_data = 32'(bus2.wr_data);
      a_done = 32'(bus2.wr_done); a_ready = 32'(bus2.wr_ready);
      a_busy = 32'(busy2); a_ovf = 32'(ovf2);
    end else begin
      n = 3; mask = 3'b111;
      a_we = 32'(bus3.we); a_addr = 32'(bus3.wr_addr); a_data = 32'(bus3.wr_data);
      a_done = 32'(bus3.wr_done); a_ready = 32'(bus3.wr_ready);
      a_busy = 32'(busy3); a_ovf = 32'(ovf3);
    end
    check($sformatf("n%0d.we", n),       a_we,    32'(m_we[u]));
    check($sformatf("n%0d.wr_addr", n),  a_addr,  32'(m_waddr[u]));
    check($sformatf("n%0d.wr_data", n),  a_data,  32'(m_wdata[u]));
    check($sformatf("n%0d.wr_done", n),  a_done,  32'(m_done[u]));
    check($sformatf("n%0d.wr_ready", n), a_ready, 32'(~m_pend[u] & mask));
    check($sformatf("n%0d.busy", n),     a_busy,  32'(|m_pend[u]));
    check($sformatf("n%0d.overflow", n), a_ovf,   32'(m_ovf[u]));
  endtask

  // Check the state left by the previous edge, then present new stimulus.
  task automatic step();
    @(negedge clk);
    check_unit(0);
    check_unit(1);
    rst = s_rst;
    bus2.wr_req = s_req[0][1:0];
    for (int i = 0; i < 2; i++) begin
      bus2.wr_addr_req[i] = s_addr[0][i];
      bus2.wr_data_req[i] = s_data[0][i];
    end
    bus3.wr_req = s_req[1];
    for (int i = 0; i < 3; i++) begin
      bus3.wr_addr_req[i] = s_addr[1][i];
      bus3.wr_data_req[i] = s_data[1][i];
    end
    model_step(0);
    model_step(1);
  endtask

  task automatic idle();
    s_req[0] = '0;
    s_req[1] = '0;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [1:0] d);
    for (int u = 0; u < 2; u++) begin
      s_addr[u][i] = a;
      s_data[u][i] = d;
    end
  endtask

  task automatic do_reset();
    idle();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst = 1'b1;
    idle();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 3; i++) begin
        s_addr[u][i] = '0; s_data[u][i] = '0;
        m_saddr[u][i] = '0; m_sdata[u][i] = '0;
      end
    rst = 1'b1;
    bus2.wr_req = '0; bus2.wr_addr_req = '0; bus2.wr_data_req = '0;
    bus3.wr_req = '0; bus3.wr_addr_req = '0; bus3.wr_data_req = '0;
    model_step(0);
    model_step(1);
    repeat (2) @(posedge clk);
    step();
    s_rst = 1'b0;

    // Single write from requester 0
    set_req(0, 8'd20, 2'd2);
    s_req[0] = 3'b001; s_req[1] = 3'b001;
    step();
    idle();
    step();
    check("single.ready_low", 32'(bus2.wr_ready[0]), 32'd0);
    step();
    check("single.we", 32'(bus2.we), 32'd1);
    check("single.addr", 32'(bus2.wr_addr), 32'd20);
    check("single.data", 32'(bus2.wr_data), 32'd2);
    check("single.done", 32'(bus2.wr_done), 32'b01);
    check("single.ready_back", 32'(bus2.wr_ready[0]), 32'd1);
    step();
    check("single.we_once", 32'(bus2.we), 32'd0);

    // Simultaneous requests after a fresh reset
    do_reset();
    set_req(0, 8'd5, 2'd2);
    set_req(1, 8'd6, 2'd0);
    s_req[0] = 3'b011; s_req[1] = 3'b011;
    step();
    idle();
    step();
    step();
    check("simul.first_done", 32'(bus2.wr_done), 32'b01);
    check("simul.first_addr", 32'(bus2.wr_addr), 32'd5);
    step();
    check("simul.second_done", 32'(bus2.wr_done), 32'b10);
    check("simul.second_addr", 32'(bus2.wr_addr), 32'd6);
    check("simul.second_we", 32'(bus2.we), 32'd1);

    // Fairness under continuous requests
    do_reset();
    s_req[0] = 3'b011; s_req[1] = 3'b011;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c >= 2) begin
        check("fair.we", 32'(bus2.we), 32'd1);
        check("fair.done", 32'(bus2.wr_done), (c % 2 == 0) ? 32'b01 : 32'b10);
      end
    end
    check("fair.overflow", 32'(ovf2), 32'd1);
    idle();
    repeat (3) step();

    // Overflow: second pulse while the slot is still pending
    do_reset();
    set_req(1, 8'd7, 2'd0);
    s_req[0] = 3'b010; s_req[1] = 3'b010;
    step();
    set_req(1, 8'd9, 2'd1);
    step();
    idle();
    step();
    check("ovf.addr", 32'(bus2.wr_addr), 32'd7);
    check("ovf.done", 32'(bus2.wr_done), 32'b10);
    check("ovf.flag", 32'(ovf2), 32'd1);
    step();
    check("ovf.no_second", 32'(bus2.we), 32'd0);
    repeat (3) step();
    check("ovf.sticky", 32'(ovf2), 32'd1);

    // Pointer wrap on the 3-requester unit
    do_reset();
    s_addr[1][2] = 8'd33; s_data[1][2] = 2'd3;
    s_req[1] = 3'b100;
    step();
    idle();
    step();
    step();
    check("wrap.grant2", 32'(bus3.wr_done), 32'b100);
    s_addr[1][0] = 8'd40; s_data[1][0] = 2'd1;
    s_addr[1][2] = 8'd41; s_data[1][2] = 2'd2;
    s_req[1] = 3'b101;
    step();
    idle();
    step();
    step();
    check("wrap.first_done", 32'(bus3.wr_done), 32'b001);
    check("wrap.first_addr", 32'(bus3.wr_addr), 32'd40);
    step();
    check("wrap.second_done", 32'(bus3.wr_done), 32'b100);
    check("wrap.second_addr", 32'(bus3.wr_addr), 32'd41);

    // Reset while both slots are pending
    do_reset();
    set_req(0, 8'd50, 2'd1);
    set_req(1, 8'd51, 2'd2);
    s_req[0] = 3'b011; s_req[1] = 3'b011;
    step();
    idle();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    step();
    check("rstmid.we", 32'(bus2.we), 32'd0);
    check("rstmid.ready", 32'(bus2.wr_ready), 32'b11);
    check("rstmid.busy", 32'(busy2), 32'd0);
    set_req(1, 8'd12, 2'd3);
    s_req[0] = 3'b010; s_req[1] = 3'b010;
    step();
    check("rstmid.no_done", 32'(bus2.wr_done), 32'd0);
    idle();
    step();
    step();
    check("rstmid.fresh_done", 32'(bus2.wr_done), 32'b10);
    check("rstmid.fresh_addr", 32'(bus2.wr_addr), 32'd12);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      s_rst = ($urandom_range(0, 199) == 0);
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < 3; i++) begin
          s_req[u][i]  = ($urandom_range(0, 99) < 45);
          s_addr[u][i] = 8'($urandom_range(0, 208));
          s_data[u][i] = 2'($urandom);
        end
      s_req[0][2] = 1'b0;
      step();
    end
    s_rst = 1'b0;
    idle();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
